// File: rtl/rst_seq_pkg.sv
// Shared types and sizing helpers for the reset sequencer.
// Optional ready handshake is enabled with the RST_SEQ_ACK_EN macro.
package rst_seq_pkg;

    typedef enum logic [1:0] {
        HOLD     = 2'd0,
        REL      = 2'd1,
        WAIT_RDY = 2'd2,
        DONE     = 2'd3
    } state_t;

    localparam int NUM_DOMAINS_DEF = 3;
    localparam int HOLD_CYCLES_DEF = 4;
    localparam int STEP_DELAY_DEF  = 2;
    localparam int ACK_TIMEOUT_DEF = 16;

    // Counter must hold the largest terminal value of any timed phase
    function automatic int cnt_width(int h, int s, int a);
        int m;
        m = h;
        if (s > m) m = s;
        if (a > m) m = a;
        return $clog2(m) + 1;
    endfunction

    localparam int CNT_W_DEF   = cnt_width(HOLD_CYCLES_DEF, STEP_DELAY_DEF,
                                           ACK_TIMEOUT_DEF);
    localparam int STAGE_W_DEF = $clog2(NUM_DOMAINS_DEF + 1);

endpackage

// File: rtl/rst_seq_timer.sv
// Up-counter with synchronous clear and terminal-count compare.
// Shared by the HOLD, REL and WAIT_RDY phases of the sequencer.
module rst_seq_timer #(
    parameter int W = 4
) (
    input  logic         i_CLK,
    input  logic         i_RST,
    input  logic         i_CLR,
    input  logic [W-1:0] i_TC_VAL,
    output logic         o_TC
);

    logic [W-1:0] r_cnt;

    // Count every edge; a clear returns to zero for the next phase
    always_ff @(posedge i_CLK or negedge i_RST) begin
        if (!i_RST)     r_cnt <= '0;
        else if (i_CLR) r_cnt <= '0;
        else            r_cnt <= r_cnt + 1'b1;
    end

    assign o_TC = (r_cnt == i_TC_VAL);

endmodule

// File: rtl/rst_sequencer.sv
// Releases per-domain active-low resets in order with fixed spacing.
// Define RST_SEQ_ACK_EN to wait for per-domain ready after each release.
module rst_sequencer
    import rst_seq_pkg::*;
#(
    parameter int NUM_DOMAINS = NUM_DOMAINS_DEF,
    parameter int HOLD_CYCLES = HOLD_CYCLES_DEF,
    parameter int STEP_DELAY  = STEP_DELAY_DEF,
    parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
    input  logic                               i_CLK,
    input  logic                               i_RST,
    input  logic                               i_SW_RST_REQ,
    output logic [NUM_DOMAINS-1:0]             o_RST_N,
    output logic [$clog2(NUM_DOMAINS+1)-1:0]   o_STAGE,
    output logic                               o_SEQ_DONE
`ifdef RST_SEQ_ACK_EN
    ,
    input  logic [NUM_DOMAINS-1:0]             i_DOMAIN_RDY,
    output logic                               o_SEQ_ERR
`endif
);

    localparam int CW = cnt_width(HOLD_CYCLES, STEP_DELAY, ACK_TIMEOUT);
    localparam int SW = $clog2(NUM_DOMAINS + 1);
    localparam int IW = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [IW-1:0]          r_idx;
    logic [IW-1:0]          w_idx_nxt;
    logic [NUM_DOMAINS-1:0] r_rst_n;
    logic [NUM_DOMAINS-1:0] w_rst_n_nxt;
    logic [SW-1:0]          r_stage;
    logic [SW-1:0]          w_stage_nxt;
    logic                   r_done;
    logic                   w_done_nxt;
    logic                   w_clr;
    logic                   w_tc;
    logic [CW-1:0]          w_tc_val;
    logic                   w_last;
`ifdef RST_SEQ_ACK_EN
    logic                   r_err;
    logic                   w_err_nxt;
    logic                   w_rdy;
    assign w_rdy = i_DOMAIN_RDY[r_idx];
`endif

    assign w_last = (r_idx == IW'(NUM_DOMAINS - 1));

    // Terminal count depends on which timed phase is active
    always_comb begin
        w_tc_val = CW'(HOLD_CYCLES - 1);
        case (r_state)
            REL:      w_tc_val = CW'(STEP_DELAY - 1);
            WAIT_RDY: w_tc_val = CW'(ACK_TIMEOUT - 1);
            default:  w_tc_val = CW'(HOLD_CYCLES - 1);
        endcase
    end

    rst_seq_timer #(
        .W (CW)
    ) u_timer (
        .i_CLK    (i_CLK),
        .i_RST    (i_RST),
        .i_CLR    (w_clr),
        .i_TC_VAL (w_tc_val),
        .o_TC     (w_tc)
    );

    // State, domain index and registered outputs
    always_ff @(posedge i_CLK or negedge i_RST) begin
        if (!i_RST) begin
            r_state <= HOLD;
            r_idx   <= '0;
            r_rst_n <= '0;
            r_stage <= '0;
            r_done  <= 1'b0;
`ifdef RST_SEQ_ACK_EN
            r_err   <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_rst_n <= w_rst_n_nxt;
            r_stage <= w_stage_nxt;
            r_done  <= w_done_nxt;
`ifdef RST_SEQ_ACK_EN
            r_err   <= w_err_nxt;
`endif
        end
    end

    // Next state, next index and timer clear; software request wins
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_clr       = 1'b0;
        if (i_SW_RST_REQ) begin
            w_state_nxt = HOLD;
            w_idx_nxt   = '0;
            w_clr       = 1'b1;
        end else begin
            case (r_state)
                HOLD: begin
                    if (w_tc) begin
                        w_clr       = 1'b1;
                        w_state_nxt = REL;
                    end
                end
                REL: begin
                    if (w_tc) begin
                        w_clr = 1'b1;
`ifdef RST_SEQ_ACK_EN
                        w_state_nxt = WAIT_RDY;
`else
                        if (w_last) w_state_nxt = DONE;
                        else        w_idx_nxt   = r_idx + 1'b1;
`endif
                    end
                end
`ifdef RST_SEQ_ACK_EN
                WAIT_RDY: begin
                    if (w_rdy || w_tc) begin
                        w_clr = 1'b1;
                        if (w_last) begin
                            w_state_nxt = DONE;
                        end else begin
                            w_state_nxt = REL;
                            w_idx_nxt   = r_idx + 1'b1;
                        end
                    end
                end
`endif
                DONE: w_clr = 1'b1;
                default: begin
                    w_state_nxt = HOLD;
                    w_idx_nxt   = '0;
                    w_clr       = 1'b1;
                end
            endcase
        end
    end

    // Output register updates for each release / completion event
    always_comb begin
        w_rst_n_nxt = r_rst_n;
        w_stage_nxt = r_stage;
        w_done_nxt  = r_done;
`ifdef RST_SEQ_ACK_EN
        w_err_nxt   = r_err;
`endif
        if (i_SW_RST_REQ) begin
            w_rst_n_nxt = '0;
            w_stage_nxt = '0;
            w_done_nxt  = 1'b0;
`ifdef RST_SEQ_ACK_EN
            w_err_nxt   = 1'b0;
`endif
        end else begin
            case (r_state)
                HOLD, DONE: ;
                REL: begin
                    if (w_tc) begin
                        w_rst_n_nxt = r_rst_n | (NUM_DOMAINS'(1) << r_idx);
                        w_stage_nxt = SW'(r_idx) + 1'b1;
`ifndef RST_SEQ_ACK_EN
                        if (w_last) w_done_nxt = 1'b1;
`endif
                    end
                end
`ifdef RST_SEQ_ACK_EN
                WAIT_RDY: begin
                    if (w_rdy || w_tc) begin
                        if (!w_rdy) w_err_nxt = 1'b1;
                        if (w_last) w_done_nxt = 1'b1;
                    end
                end
`endif
                default: begin
                    w_rst_n_nxt = '0;
                    w_stage_nxt = '0;
                    w_done_nxt  = 1'b0;
                end
            endcase
        end
    end

    assign o_RST_N    = r_rst_n;
    assign o_STAGE    = r_stage;
    assign o_SEQ_DONE = r_done;
`ifdef RST_SEQ_ACK_EN
    assign o_SEQ_ERR  = r_err;
`endif

endmodule

// File: tb/tb_rst_sequencer.sv
// Directed self-checking bench for rst_sequencer.
// Covers defaults plus a single-domain instance; RST_SEQ_ACK_EN build too.
module tb_rst_sequencer;

    logic       clk;
    logic       rst_n;
    logic       sw_req;
    logic [2:0] rst_vec;
    logic [1:0] stage;
    logic       done;
    logic       s_rst;
    logic       s_stage;
    logic       s_done;
`ifdef RST_SEQ_ACK_EN
    logic       err;
    logic       s_err;
`endif

    int n_chk;
    int n_pass;

    rst_sequencer u_dut (
        .i_CLK        (clk),
        .i_RST        (rst_n),
        .i_SW_RST_REQ (sw_req),
        .o_RST_N      (rst_vec),
        .o_STAGE      (stage),
        .o_SEQ_DONE   (done)
`ifdef RST_SEQ_ACK_EN
        ,
        .i_DOMAIN_RDY (3'b101),
        .o_SEQ_ERR    (err)
`endif
    );

    rst_sequencer #(
        .NUM_DOMAINS (1),
        .HOLD_CYCLES (1),
        .STEP_DELAY  (1)
    ) u_dut1 (
        .i_CLK        (clk),
        .i_RST        (rst_n),
        .i_SW_RST_REQ (1'b0),
        .o_RST_N      (s_rst),
        .o_STAGE      (s_stage),
        .o_SEQ_DONE   (s_done)
`ifdef RST_SEQ_ACK_EN
        ,
        .i_DOMAIN_RDY (1'b1),
        .o_SEQ_ERR    (s_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        rst_n  = 1'b0;
        sw_req = 1'b0;
        #1;
        chk("rst_vec", {29'd0, rst_vec}, 32'h0);
        chk("rst_stage", {30'd0, stage}, 32'h0);
        chk("rst_done", {31'd0, done}, 32'h0);
        #6 rst_n = 1'b1;
`ifndef RST_SEQ_ACK_EN
        tick(1);
        chk("s_e1", {31'd0, s_rst}, 32'h0);
        tick(1);
        chk("s_e2", {31'd0, s_rst}, 32'h1);
        chk("s_e2_done", {31'd0, s_done}, 32'h1);
        chk("s_e2_stage", {31'd0, s_stage}, 32'h1);
        tick(3);
        chk("e5", {29'd0, rst_vec}, 32'h0);
        tick(1);
        chk("e6", {29'd0, rst_vec}, 32'h1);
        chk("e6_stage", {30'd0, stage}, 32'h1);
        tick(2);
        chk("e8", {29'd0, rst_vec}, 32'h3);
        tick(1);
        chk("e9", {29'd0, rst_vec}, 32'h3);
        chk("e9_done", {31'd0, done}, 32'h0);
        tick(1);
        chk("e10", {29'd0, rst_vec}, 32'h7);
        chk("e10_stage", {30'd0, stage}, 32'h3);
        chk("e10_done", {31'd0, done}, 32'h1);
        // software request held for three edges while in DONE
        sw_req = 1'b1;
        tick(1);
        chk("sw_vec", {29'd0, rst_vec}, 32'h0);
        chk("sw_stage", {30'd0, stage}, 32'h0);
        chk("sw_done", {31'd0, done}, 32'h0);
        tick(2);
        sw_req = 1'b0;
        tick(5);
        chk("sw_d5", {29'd0, rst_vec}, 32'h0);
        tick(1);
        chk("sw_d6", {29'd0, rst_vec}, 32'h1);
        tick(2);
        chk("sw_b1", {29'd0, rst_vec}, 32'h3);
        // one-cycle request during REL aborts the partial sequence
        sw_req = 1'b1;
        tick(1);
        sw_req = 1'b0;
        chk("ab_vec", {29'd0, rst_vec}, 32'h0);
        chk("ab_stage", {30'd0, stage}, 32'h0);
        tick(5);
        chk("ab_e5", {29'd0, rst_vec}, 32'h0);
        tick(1);
        chk("ab_e6", {29'd0, rst_vec}, 32'h1);
        // asynchronous reset mid-sequence
        #2 rst_n = 1'b0;
        #1;
        chk("as_vec", {29'd0, rst_vec}, 32'h0);
        chk("as_stage", {30'd0, stage}, 32'h0);
        rst_n = 1'b1;
        tick(5);
        chk("as_e5", {29'd0, rst_vec}, 32'h0);
        tick(1);
        chk("as_e6", {29'd0, rst_vec}, 32'h1);
        tick(4);
        chk("as_e10", {29'd0, rst_vec}, 32'h7);
        chk("as_done", {31'd0, done}, 32'h1);
        chk("as_stage3", {30'd0, stage}, 32'h3);
        tick(4);
        chk("ab_fin", {29'd0, rst_vec}, 32'h7);
`else
        tick(2);
        chk("s_e2", {31'd0, s_rst}, 32'h1);
        chk("s_e2_done", {31'd0, s_done}, 32'h0);
        tick(1);
        chk("s_e3_done", {31'd0, s_done}, 32'h1);
        tick(3);
        chk("e6", {29'd0, rst_vec}, 32'h1);
        tick(3);
        chk("e9", {29'd0, rst_vec}, 32'h3);
        chk("e9_err", {31'd0, err}, 32'h0);
        tick(15);
        chk("e24_err", {31'd0, err}, 32'h0);
        tick(1);
        chk("e25_err", {31'd0, err}, 32'h1);
        chk("e25_vec", {29'd0, rst_vec}, 32'h3);
        tick(2);
        chk("e27_vec", {29'd0, rst_vec}, 32'h7);
        chk("e27_done", {31'd0, done}, 32'h0);
        tick(1);
        chk("e28_done", {31'd0, done}, 32'h1);
        sw_req = 1'b1;
        tick(1);
        sw_req = 1'b0;
        chk("sw_err", {31'd0, err}, 32'h0);
        chk("sw_vec", {29'd0, rst_vec}, 32'h0);
        chk("s_err", {31'd0, s_err}, 32'h0);
`endif
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/rst_sequencer.md
Name: rst_sequencer

Overview:
- Consumes the synchronized, active-low reset from the reset synchronizer stage.
- Releases per-domain resets one at a time, in fixed order and with fixed spacing. Domains are register file, ALU, UART, and so on.
- Also supports a software-requested full re-sequence without a new power-on reset.
- Sits between the reset synchronizer output and the reset pins of the downstream sub-blocks in the same clock domain.

Parameters:
- NUM_DOMAINS, 3: number of independently released reset outputs; must be ≥1.
- HOLD_CYCLES, 4: cycles all resets stay asserted after the sequence starts; must be ≥1.
- STEP_DELAY, 2: cycles between consecutive domain releases, and before the first release; must be ≥1.
- ACK_TIMEOUT, 16: maximum cycles to wait for a domain-ready response; used only with RST_SEQ_ACK_EN.

Ports:
- i_CLK  in  1  system clock.
- i_RST  in  1  asynchronous active-low reset; driven by the synchronizer's o_SYNC_RST.
- i_SW_RST_REQ  in  1  level request to re-run the sequence; sampled on rising i_CLK.
- o_RST_N  out  NUM_DOMAINS  active-low per-domain resets; bit 0 is released first.
- o_STAGE  out  clog2(NUM_DOMAINS+1)  number of domains currently released.
- o_SEQ_DONE  out  1  high when all domains are released.

Behaviour:
- **Reset values** (i_RST=0, asynchronous): o_RST_N=0 (all asserted), o_STAGE=0, o_SEQ_DONE=0, state=HOLD, cnt=0, idx=0. All outputs are registered; there are no combinational output paths.
- **Edge numbering:** edge 1 is the first rising i_CLK with i_RST=1.
- **HOLD:**
  - cnt increments every edge.
  - When cnt==HOLD_CYCLES-1: cnt←0, go to REL.
- **REL:**
  - cnt increments every edge.
  - When cnt==STEP_DELAY-1: o_RST_N[idx]←1, o_STAGE←idx+1, cnt←0.
  - If idx==NUM_DOMAINS-1: go to DONE and set o_SEQ_DONE←1 on the same edge. Otherwise idx←idx+1.
- **Release timing:** o_RST_N[k] goes high after edge HOLD_CYCLES+(k+1)·STEP_DELAY. With defaults: bit0 after edge 6, bit1 after edge 8, bit2 and o_SEQ_DONE after edge 10.
- **DONE:** outputs are stable; stays in DONE until a request arrives.
- **i_SW_RST_REQ=1 at any edge, in any state** (highest priority among synchronous events):
  - o_RST_N←0, o_SEQ_DONE←0, o_STAGE←0, idx←0, cnt←0, state←HOLD.
  - While the request stays high, cnt is held at 0. The HOLD count therefore starts from the first edge with the request low.
- **Request during REL:** the partial sequence is aborted. Already-released domains are re-asserted on the next edge.
- **Asynchronous reset mid-sequence:** immediate return to the reset values, regardless of state.
- **Single domain (NUM_DOMAINS=1):** the first release goes directly to DONE.
- **Counter width:** clog2(max(HOLD_CYCLES,STEP_DELAY,ACK_TIMEOUT))+1. The counter never wraps because it is cleared on every terminal count.
- **Unused encodings:** any illegal state goes to HOLD with all resets asserted.

Optional Feature:
- **RST_SEQ_ACK_EN defined:**
  - Adds input i_DOMAIN_RDY [NUM_DOMAINS-1] and sticky output o_SEQ_ERR (reset 0; cleared by a software request).
  - Adds a WAIT_RDY state, entered after each release.
  - The FSM leaves WAIT_RDY on the first edge that samples i_DOMAIN_RDY[idx]=1. It then continues in REL with the next step count, or goes to DONE after the last domain.
  - If ACK_TIMEOUT cycles elapse without ready: o_SEQ_ERR←1 and the sequence proceeds anyway.
  - o_SEQ_DONE rises only on leaving WAIT_RDY for the last domain.
- **RST_SEQ_ACK_EN undefined:** purely timed sequencing, exactly as in Behaviour. The extra ports and WAIT_RDY state do not exist.

Decomposition:
- Package rst_seq_pkg holds:
  - the state enum: HOLD, REL, WAIT_RDY, DONE;
  - localparams for counter width and o_STAGE width;
  - the default values of HOLD_CYCLES and STEP_DELAY.
- One natural sub-module, rst_seq_timer: a loadable up-counter with synchronous clear and a terminal-count compare. It is shared by the HOLD, REL and WAIT_RDY timing.

Test Plan:
- Default params, i_RST low 7 ns then high → o_RST_N 000→001 after edge 6, 011 after edge 8, 111 after edge 10; o_SEQ_DONE=1 after edge 10.
- i_RST pulsed low at edge 7 (bit0 released) → o_RST_N=000 and o_STAGE=0 immediately (asynchronous); sequence restarts from edge 1 on release.
- In DONE, i_SW_RST_REQ high for 3 edges → all outputs cleared on the first edge; bit0 released 6 edges after the request drops.
- i_SW_RST_REQ pulsed for 1 cycle after bit1 is released (REL) → o_RST_N=000 on the next edge; full re-sequence follows, ending with 111.
- NUM_DOMAINS=1, HOLD_CYCLES=1, STEP_DELAY=1 → o_RST_N=1 and o_SEQ_DONE=1 after edge 2.
- With RST_SEQ_ACK_EN: i_DOMAIN_RDY[1] tied 0, ACK_TIMEOUT=16 → o_SEQ_ERR=1 16 cycles after bit1 is released, then bit2 is released and o_SEQ_DONE=1.
